// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
// Purpose: FSM state encoding, index-width helper and one-hot decoder used by
//          fifo_wr_arbiter and rr_pick.
// Ports:   none (package).
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Widest requester vector the one-hot helper can produce; callers cast down.
  localparam int unsigned ONEHOT_W = 32;

  // Index width for n requesters; never below 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin requester picker
// Purpose: choose the first requester with req=1 searching last_owner+1,
//          last_owner+2, ... (mod NREQ).
// Ports:   req        in   NREQ   request levels
//          last_owner in   IDX_W  previous grant holder
//          found      out  1      at least one request present
//          idx        out  IDX_W  chosen requester (0 when found=0)
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_owner,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan the rotated order from farthest to nearest so the nearest
  // requester after last_owner is the final (winning) assignment. This is the
  // rotate / priority-encode / un-rotate sequence folded into one loop.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_owner) + k) % NREQ]) begin
        idx = IDX_W'((int'(last_owner) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter for the async FIFO write port
// Purpose: grants one requester at a time for bursts of up to BURST_MAX beats,
//          throttles on wfull and counts owner stall cycles (saturating).
// Ports:   wclk, wrst      in   clock, async active-high reset
//          req, req_data   in   per-requester beat-valid and flattened data
//          ack, grant      out  per-requester beat accept, current owner
//          wfull           in   FIFO full flag
//          winc, wdata     out  FIFO write enable and data
//          stall_cnt       out  saturating count of owner-stalled cycles
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned datawidth = 8,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned STALL_W   = 16
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*datawidth-1:0] req_data,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           grant,
  input  logic                      wfull,
  output logic                      winc,
  output logic [datawidth-1:0]      wdata,
  output logic [STALL_W-1:0]        stall_cnt
);

  localparam int unsigned IDX_W  = idx_width(NREQ);
  localparam int unsigned BEAT_W = $clog2(BURST_MAX) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_q;
  logic [NREQ-1:0]    grant_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [STALL_W-1:0] stall_q;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               own_req;
  logic               beat_ok;
  logic               stall_now;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .last_owner (last_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // grant_q is zero outside BURST, so masking with it also gates ack in IDLE.
  assign own_req   = req[owner_q];
  assign ack       = grant_q & req & {NREQ{~wfull}};
  assign beat_ok   = |ack;
  assign winc      = beat_ok;
  assign wdata     = beat_ok ? req_data[32'(owner_q)*datawidth +: datawidth] : '0;
  assign stall_now = (state_q == BURST) && own_req && wfull;
  assign grant     = grant_q;
  assign stall_cnt = stall_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      grant_q <= '0;
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (stall_now && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            grant_q <= NREQ'(onehot(32'(pick_idx)));
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          // Either exit leaves one IDLE bubble before the next grant.
          if (!own_req || (beat_ok && beat_q == LAST_BEAT)) begin
            last_q  <= owner_q;
            grant_q <= '0;
            state_q <= IDLE;
          end else if (beat_ok) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
